// File: rtl/osc_pkg.sv
// osc_pkg: shared types and constants for the oscillator frequency meter.
//   osc_state_e  - measurement FSM states (SEEK / MEASURE / DIVIDE)
//   CLK_HZ_DEF   - default system clock rate in Hz
//   FREQ_W, SAMPLE_W, DIV_W, FREQ_MAX - datapath widths and output ceiling
//   sat_freq()   - clamps a divider quotient to the 12-bit Hz code
package osc_pkg;

    typedef enum logic [1:0] {
        SEEK    = 2'd0,
        MEASURE = 2'd1,
        DIVIDE  = 2'd2
    } osc_state_e;

    localparam int              CLK_HZ_DEF = 1000000;
    localparam int              FREQ_W     = 12;
    localparam int              SAMPLE_W   = 16;
    localparam int              DIV_W      = 21;
    localparam logic [FREQ_W-1:0] FREQ_MAX = 12'd4095;

    // Quotients above the 12-bit range report the ceiling code.
    function automatic logic [FREQ_W-1:0] sat_freq(input logic [DIV_W-1:0] q);
        logic [FREQ_W-1:0] r;
        if (q > {{(DIV_W-FREQ_W){1'b0}}, FREQ_MAX}) begin
            r = FREQ_MAX;
        end else begin
            r = q[FREQ_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/osc_udiv.sv
// osc_udiv: sequential restoring unsigned divider, one quotient bit per clock.
//   clk, rst_n - clock, asynchronous active-low reset (aborts a division)
//   start      - load dividend/divisor and begin (accepted when idle)
//   dividend   - W-bit numerator
//   divisor    - W-bit denominator; zero yields an all-ones quotient
//   busy       - high while quotient bits are being produced
//   done       - one-cycle pulse in the cycle after the last bit
//   quotient   - result, valid while done is high and held until next start
module osc_udiv #(
    parameter int W = 21
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     rem_r;
    logic [W-1:0]     quo_r;
    logic [W-1:0]     div_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic             busy_r;
    logic             done_r;

    logic [W:0]       shift_s;
    logic [W-1:0]     diff_s;
    logic             ge_s;

    // Trial subtraction: shift next dividend bit into the partial remainder.
    // The true difference is below 2^W whenever it is used, so W bits suffice.
    always_comb begin
        shift_s = {rem_r, quo_r[W-1]};
        ge_s    = (shift_s >= {1'b0, div_r});
        diff_s  = shift_s[W-1:0] - div_r;
    end

    // Division state: load on start, then one restoring step per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_r     <= '0;
            quo_r     <= '0;
            div_r     <= '0;
            bit_cnt_r <= '0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start && !busy_r) begin
                rem_r     <= '0;
                quo_r     <= dividend;
                div_r     <= divisor;
                bit_cnt_r <= CNT_W'(W);
                busy_r    <= 1'b1;
            end else if (busy_r) begin
                if (ge_s) begin
                    rem_r <= diff_s;
                    quo_r <= {quo_r[W-2:0], 1'b1};
                end else begin
                    rem_r <= shift_s[W-1:0];
                    quo_r <= {quo_r[W-2:0], 1'b0};
                end
                bit_cnt_r <= bit_cnt_r - CNT_W'(1);
                if (bit_cnt_r == CNT_W'(1)) begin
                    busy_r <= 1'b0;
                    done_r <= 1'b1;
                end else begin
                    busy_r <= 1'b1;
                end
            end else begin
                busy_r <= 1'b0;
            end
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign quotient = quo_r;

endmodule

// File: rtl/osc_freq_meter.sv
// osc_freq_meter: measures the fundamental of a signed sample stream via
// hysteretic upward zero crossings and reports it as a 12-bit Hz code.
//   clk, rst_n    - system clock, asynchronous active-low reset
//   sample_valid  - sample qualifies this cycle
//   sample        - 16-bit signed input
//   freq          - rounded, saturated frequency in Hz
//   freq_valid    - one-cycle pulse when freq updates
//   period        - last measured period in clocks
//   locked        - a full period has been measured since reset/timeout
//   timeout       - one-cycle pulse when the period counter saturates
// Parameters: CLK_HZ (< 2^20), PERIOD_W (<= DIV_W), HYST (arming magnitude).
module osc_freq_meter
    import osc_pkg::*;
#(
    parameter int CLK_HZ   = CLK_HZ_DEF,
    parameter int PERIOD_W = 20,
    parameter int HYST     = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_valid,
    input  logic [15:0]         sample,
    output logic [11:0]         freq,
    output logic                freq_valid,
    output logic [PERIOD_W-1:0] period,
    output logic                locked,
    output logic                timeout
);

    localparam logic signed [SAMPLE_W-1:0] NEG_HYST_C = SAMPLE_W'(-HYST);
    localparam logic [PERIOD_W-1:0]        CNT_MAX_C  = '1;
    localparam logic [PERIOD_W-1:0]        CNT_PRE_C  = CNT_MAX_C - PERIOD_W'(1);

    osc_state_e           state_r;
    logic                 armed_r;
    logic [PERIOD_W-1:0]  cnt_r;
    logic                 pending_r;
    logic                 to_r;          // timeout seen while a division runs
    logic [FREQ_W-1:0]    freq_r;
    logic                 freq_valid_r;
    logic [PERIOD_W-1:0]  period_r;
    logic                 locked_r;
    logic                 timeout_r;

    logic signed [SAMPLE_W-1:0] sample_s;
    logic                 arm_s;
    logic                 cross_s;
    logic                 sat_s;
    logic                 div_start_s;
    logic [PERIOD_W-1:0]  div_divisor_s;
    logic [DIV_W-1:0]     div_dividend_s;
    logic                 div_busy_s;
    logic                 div_done_s;
    logic [DIV_W-1:0]     div_quot_s;

    assign sample_s = $signed(sample);

    // Arm well below zero, fire on the first non-negative sample afterwards.
    // The two conditions are disjoint in sign, so they never coincide.
    always_comb begin
        arm_s   = sample_valid && (sample_s <= NEG_HYST_C);
        cross_s = armed_r && sample_valid && (sample_s[SAMPLE_W-1] == 1'b0);
        // Saturation event is the edge on which cnt reaches its maximum.
        sat_s   = !cross_s && (cnt_r == CNT_PRE_C);
    end

    // Arming flag and free-running period counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            if (cross_s) begin
                armed_r <= 1'b0;
            end else if (arm_s) begin
                armed_r <= 1'b1;
            end else begin
                armed_r <= armed_r;
            end
            if (cross_s) begin
                cnt_r <= PERIOD_W'(1);
            end else if (cnt_r != CNT_MAX_C) begin
                cnt_r <= cnt_r + PERIOD_W'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Divider launch: a fresh period from cnt on a crossing, otherwise the
    // queued period when a result completes with one pending. A crossing on
    // the completion edge supersedes the queued value (latest period wins).
    always_comb begin
        div_start_s   = 1'b0;
        div_divisor_s = period_r;
        case (state_r)
            MEASURE: begin
                if (cross_s) begin
                    div_start_s   = 1'b1;
                    div_divisor_s = cnt_r;
                end else begin
                    div_start_s = 1'b0;
                end
            end
            DIVIDE: begin
                if (div_done_s && !to_r && !sat_s) begin
                    if (cross_s) begin
                        div_start_s   = 1'b1;
                        div_divisor_s = cnt_r;
                    end else if (pending_r) begin
                        div_start_s = 1'b1;
                    end else begin
                        div_start_s = 1'b0;
                    end
                end else begin
                    div_start_s = 1'b0;
                end
            end
            default: begin
                div_start_s = 1'b0;
            end
        endcase
        // Adding half the period before dividing rounds to nearest.
        div_dividend_s = DIV_W'(CLK_HZ) + DIV_W'(div_divisor_s >> 1);
    end

    osc_udiv #(
        .W (DIV_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start_s && !div_busy_s),
        .dividend (div_dividend_s),
        .divisor  (DIV_W'(div_divisor_s)),
        .busy     (div_busy_s),
        .done     (div_done_s),
        .quotient (div_quot_s)
    );

    // Measurement FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= SEEK;
            pending_r    <= 1'b0;
            to_r         <= 1'b0;
            freq_r       <= '0;
            freq_valid_r <= 1'b0;
            period_r     <= '0;
            locked_r     <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            freq_valid_r <= 1'b0;
            timeout_r    <= 1'b0;
            case (state_r)
                SEEK: begin
                    if (cross_s) begin
                        state_r <= MEASURE;
                    end else begin
                        state_r <= SEEK;
                    end
                end
                MEASURE: begin
                    if (cross_s) begin
                        period_r <= cnt_r;
                        locked_r <= 1'b1;
                        state_r  <= DIVIDE;
                    end else if (sat_s) begin
                        timeout_r <= 1'b1;
                        locked_r  <= 1'b0;
                        state_r   <= SEEK;
                    end else begin
                        state_r <= MEASURE;
                    end
                end
                DIVIDE: begin
                    // After a timeout, later crossings no longer feed results.
                    if (cross_s && !to_r) begin
                        period_r <= cnt_r;
                    end else begin
                        period_r <= period_r;
                    end
                    if (sat_s) begin
                        timeout_r <= 1'b1;
                        locked_r  <= 1'b0;
                        pending_r <= 1'b0;
                        to_r      <= 1'b1;
                    end else begin
                        timeout_r <= 1'b0;
                    end
                    if (div_done_s) begin
                        freq_r       <= sat_freq(div_quot_s);
                        freq_valid_r <= 1'b1;
                        if (to_r || sat_s) begin
                            to_r      <= 1'b0;
                            pending_r <= 1'b0;
                            state_r   <= SEEK;
                        end else if (div_start_s) begin
                            pending_r <= 1'b0;
                            state_r   <= DIVIDE;
                        end else begin
                            state_r <= MEASURE;
                        end
                    end else if (cross_s && !to_r) begin
                        pending_r <= 1'b1;
                    end else begin
                        state_r <= DIVIDE;
                    end
                end
                default: begin
                    state_r <= SEEK;
                end
            endcase
        end
    end

    assign freq       = freq_r;
    assign freq_valid = freq_valid_r;
    assign period     = period_r;
    assign locked     = locked_r;
    assign timeout    = timeout_r;

endmodule
